// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the select/ALU encodings driven into the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_HALT
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD  = 2'b00,
      ALUOP_SUB  = 2'b01,
      ALUOP_FUNC = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:  imm_src_of = IMM_S;
         OP_BRANCH: imm_src_of = IMM_B;
         OP_JAL:    imm_src_of = IMM_J;
         default:   imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode; flags funct3 values the controller does
// not implement so the FSM can halt on them.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t      alu_op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        op5,
   output logic [2:0]  alu_control,
   output logic        illegal
);

   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (alu_op)
         ALUOP_SUB: begin
            alu_control = ALU_SUB;
            illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         ALUOP_FUNC: begin
            // op5 separates R-type from I-type so addi never becomes sub
            case (funct3)
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: illegal = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I datapath with memory-ready handshake
// and illegal-instruction halt. Optional retire counter: MULTICYCLE_CONTROLLER_INSTRET_EN.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter logic RESET_STATE_FETCH = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   input  logic        V,
   input  logic        MemReady,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic        AdrSrc,
   output logic [2:0]  ALUControl,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        MemWrite,
`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
   output logic        InstrRet,
   output logic [31:0] Instret,
`endif
   output logic        Halted
);

   state_t      state;
   aluop_t      alu_op;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [2:0]  dec_alu;
   logic        dec_illegal;
   logic        unused_instr_bits;

   assign op                = Instr[6:0];
   assign funct3            = Instr[14:12];
   assign funct7b5          = Instr[30];
   assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

   function automatic logic branch_taken(input logic [2:0] f3, input logic n, input logic z,
                                         input logic c, input logic v);
      case (f3)
         3'b000:  branch_taken = z;
         3'b001:  branch_taken = !z;
         3'b100:  branch_taken = n ^ v;
         3'b101:  branch_taken = !(n ^ v);
         3'b110:  branch_taken = !c;
         3'b111:  branch_taken = c;
         default: branch_taken = 1'b0;
      endcase
   endfunction

   always_comb begin
      case (state)
         S_EXECUTER, S_EXECUTEI: alu_op = ALUOP_FUNC;
         S_BRANCH:               alu_op = ALUOP_SUB;
         default:                alu_op = ALUOP_ADD;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (dec_alu),
      .illegal     (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RESET_STATE_FETCH ? S_FETCH : S_HALT;
      end else begin
         case (state)
            S_FETCH:    if (MemReady) state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: state <= S_MEMADR;
                  OP_RTYPE:          state <= S_EXECUTER;
                  OP_ITYPE:          state <= S_EXECUTEI;
                  OP_BRANCH:         state <= S_BRANCH;
                  OP_JAL:            state <= S_JAL;
                  default:           state <= S_HALT;
               endcase
            end
            S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (MemReady) state <= S_FETCH;
            S_EXECUTER,
            S_EXECUTEI: state <= dec_illegal ? S_HALT : S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= dec_illegal ? S_HALT : S_FETCH;
            S_JAL:      state <= S_ALUWB;
            S_HALT:     state <= S_HALT;
            default:    state <= S_HALT;
         endcase
      end
   end

   // Moore decode of state; the fetch and branch enables also follow live inputs.
   always_comb begin
      ImmSrc     = imm_src_of(op);
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_WD;
      ResultSrc  = RES_ALUOUT;
      AdrSrc     = 1'b0;
      ALUControl = dec_alu;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      case (state)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: ALUSrcA = SRCA_A;
         S_EXECUTEI: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA = SRCA_A;
            PCWrite = branch_taken(funct3, N, Z, C, V) && !dec_illegal;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // Reset overrides everything so an aborted access never leaks a write.
      if (!reset) begin
         ImmSrc     = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ResultSrc  = 2'b00;
         AdrSrc     = 1'b0;
         ALUControl = 3'b000;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemWrite   = 1'b0;
      end
   end

   assign Halted = (state == S_HALT);

`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
   assign InstrRet = reset && ((state == S_MEMWB) || (state == S_ALUWB) ||
                               ((state == S_MEMWRITE) && MemReady) ||
                               ((state == S_BRANCH) && !dec_illegal));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        Instret <= 32'd0;
      else if (InstrRet) Instret <= Instret + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control signature checks
// for each instruction class, stalls, halts and asynchronous reset.
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic        N, Z, C, V;
   logic        MemReady;
   logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
   logic        AdrSrc;
   logic [2:0]  ALUControl;
   logic        IRWrite, PCWrite, RegWrite, MemWrite, Halted;
`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
   logic        InstrRet;
   logic [31:0] Instret;
`endif

   int checks = 0;
   int errors = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .N          (N),
      .Z          (Z),
      .C          (C),
      .V          (V),
      .MemReady   (MemReady),
      .ImmSrc     (ImmSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .AdrSrc     (AdrSrc),
      .ALUControl (ALUControl),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
      .InstrRet   (InstrRet),
      .Instret    (Instret),
`endif
      .Halted     (Halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Signature layout: {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
   //                    IRWrite, PCWrite, RegWrite, MemWrite, Halted}
   function automatic logic [16:0] pack(input int imm, input int a, input int b, input int res,
                                        input int adr, input int alu, input int ir, input int pc,
                                        input int rw, input int mw, input int h);
      logic [1:0] imm2, a2, b2, res2;
      logic [2:0] alu3;
      imm2 = imm[1:0]; a2 = a[1:0]; b2 = b[1:0]; res2 = res[1:0]; alu3 = alu[2:0];
      return {imm2, a2, b2, res2, adr[0], alu3, ir[0], pc[0], rw[0], mw[0], h[0]};
   endfunction

   function automatic logic [16:0] obs();
      return {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
              IRWrite, PCWrite, RegWrite, MemWrite, Halted};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; Instr = 32'h0; MemReady = 1'b0; {N, Z, C, V} = 4'b0;
      #2;
      checks++;
      if (obs() !== 17'h0) begin
         errors++; $display("FAIL reset_async got=%h exp=%h", obs(), 17'h0);
      end
      tick(); tick();
      checks++;
      if (obs() !== 17'h0) begin
         errors++; $display("FAIL reset_held got=%h exp=%h", obs(), 17'h0);
      end
      reset = 1'b1;
      #4;
      checks++;
      if (obs() !== pack(0,0,2,2,0,0,0,0,0,0,0)) begin
         errors++; $display("FAIL reset_fetch got=%h exp=%h", obs(), pack(0,0,2,2,0,0,0,0,0,0,0));
      end
      tick();
   endtask

   task automatic test_add();
      logic [16:0] e [7];
      logic        mr [7];
      Instr = 32'h002081B3; {N, Z, C, V} = 4'b0;
      e[0] = pack(0,0,2,2,0,0,0,0,0,0,0); mr[0] = 1'b0;
      e[1] = pack(0,0,2,2,0,0,0,0,0,0,0); mr[1] = 1'b0;
      e[2] = pack(0,0,2,2,0,0,1,1,0,0,0); mr[2] = 1'b1;
      e[3] = pack(0,1,1,0,0,0,0,0,0,0,0); mr[3] = 1'b1;
      e[4] = pack(0,2,0,0,0,0,0,0,0,0,0); mr[4] = 1'b1;
      e[5] = pack(0,0,0,0,0,0,0,0,1,0,0); mr[5] = 1'b1;
      e[6] = pack(0,0,2,2,0,0,0,0,0,0,0); mr[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         MemReady = mr[i];
         #4;
         checks++;
         if (obs() !== e[i]) begin
            errors++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_alu_decode();
      logic [31:0] ins  [10] = '{32'h402081B3, 32'h0020A1B3, 32'h0020E1B3, 32'h0020F1B3,
                                 32'h00500093, 32'h40000093, 32'h0050A093, 32'h0050E093,
                                 32'h0050F093, 32'h002081B3};
      int          srcb [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
      int          alu  [10] = '{1, 5, 3, 2, 0, 0, 5, 3, 2, 0};
      logic [16:0] e [5];
      logic        mr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 10; k++) begin
         Instr = ins[k];
         e[0] = pack(0,0,2,2,0,0,1,1,0,0,0);
         e[1] = pack(0,1,1,0,0,0,0,0,0,0,0);
         e[2] = pack(0,2,srcb[k],0,0,alu[k],0,0,0,0,0);
         e[3] = pack(0,0,0,0,0,0,0,0,1,0,0);
         e[4] = pack(0,0,2,2,0,0,0,0,0,0,0);
         for (int i = 0; i < 5; i++) begin
            MemReady = mr[i];
            #4;
            checks++;
            if (obs() !== e[i]) begin
               errors++;
               $display("FAIL alu_decode instr=%h cyc%0d got=%h exp=%h", ins[k], i, obs(), e[i]);
            end
            tick();
         end
      end
   endtask

   task automatic test_lw_stall();
      logic [16:0] e [9];
      logic        mr [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      Instr = 32'h0000A283;
      e[0] = pack(0,0,2,2,0,0,1,1,0,0,0);
      e[1] = pack(0,1,1,0,0,0,0,0,0,0,0);
      e[2] = pack(0,2,1,0,0,0,0,0,0,0,0);
      e[3] = pack(0,0,0,0,1,0,0,0,0,0,0);
      e[4] = pack(0,0,0,0,1,0,0,0,0,0,0);
      e[5] = pack(0,0,0,0,1,0,0,0,0,0,0);
      e[6] = pack(0,0,0,0,1,0,0,0,0,0,0);
      e[7] = pack(0,0,0,1,0,0,0,0,1,0,0);
      e[8] = pack(0,0,2,2,0,0,0,0,0,0,0);
      for (int i = 0; i < 9; i++) begin
         MemReady = mr[i];
         #4;
         checks++;
         if (obs() !== e[i]) begin
            errors++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_sw();
      logic [16:0] e [6];
      logic        mr [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      Instr = 32'h0050A023;
      e[0] = pack(1,0,2,2,0,0,1,1,0,0,0);
      e[1] = pack(1,1,1,0,0,0,0,0,0,0,0);
      e[2] = pack(1,2,1,0,0,0,0,0,0,0,0);
      e[3] = pack(1,0,0,0,1,0,0,0,0,1,0);
      e[4] = pack(1,0,0,0,1,0,0,0,0,1,0);
      e[5] = pack(1,0,2,2,0,0,0,0,0,0,0);
      for (int i = 0; i < 6; i++) begin
         MemReady = mr[i];
         #4;
         checks++;
         if (obs() !== e[i]) begin
            errors++; $display("FAIL sw cyc%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins   [9] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h0020C463,
                                 32'h0020D463, 32'h0020D463, 32'h0020E463, 32'h0020F463,
                                 32'h0020F463};
      logic [3:0]  flags [9] = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1000,
                                 4'b0000, 4'b0000, 4'b0010};
      int          taken [9] = '{1, 0, 1, 1, 1, 0, 1, 0, 1};
      logic [16:0] e [4];
      logic        mr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 9; k++) begin
         Instr = ins[k];
         {N, Z, C, V} = flags[k];
         e[0] = pack(2,0,2,2,0,0,1,1,0,0,0);
         e[1] = pack(2,1,1,0,0,0,0,0,0,0,0);
         e[2] = pack(2,2,0,0,0,1,0,taken[k],0,0,0);
         e[3] = pack(2,0,2,2,0,0,0,0,0,0,0);
         for (int i = 0; i < 4; i++) begin
            MemReady = mr[i];
            #4;
            checks++;
            if (obs() !== e[i]) begin
               errors++;
               $display("FAIL branch instr=%h nzcv=%b cyc%0d got=%h exp=%h",
                        ins[k], flags[k], i, obs(), e[i]);
            end
            tick();
         end
      end
      {N, Z, C, V} = 4'b0;
   endtask

   task automatic test_jal();
      logic [16:0] e [5];
      logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      Instr = 32'h010000EF;
      e[0] = pack(3,0,2,2,0,0,1,1,0,0,0);
      e[1] = pack(3,1,1,0,0,0,0,0,0,0,0);
      e[2] = pack(3,1,2,0,0,0,0,1,0,0,0);
      e[3] = pack(3,0,0,0,0,0,0,0,1,0,0);
      e[4] = pack(3,0,2,2,0,0,0,0,0,0,0);
      for (int i = 0; i < 5; i++) begin
         MemReady = mr[i];
         #4;
         checks++;
         if (obs() !== e[i]) begin
            errors++; $display("FAIL jal cyc%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
   endtask

`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
   task automatic test_instret();
      logic [31:0] seq [3] = '{32'h002081B3, 32'h0050A023, 32'h010000EF};
      int          pulses = 0;
      reset = 1'b0;
      #2;
      checks++;
      if (Instret !== 32'd0) begin
         errors++; $display("FAIL instret_reset got=%0d exp=0", Instret);
      end
      tick();
      reset = 1'b1;
      MemReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         Instr = seq[k];
         for (int i = 0; i < 4; i++) begin
            #4;
            if (InstrRet === 1'b1) pulses++;
            tick();
         end
      end
      MemReady = 1'b0;
      checks++;
      if (Instret !== 32'd3) begin
         errors++; $display("FAIL instret_count got=%0d exp=3", Instret);
      end
      checks++;
      if (pulses != 3) begin
         errors++; $display("FAIL instret_pulses got=%0d exp=3", pulses);
      end
   endtask
`endif

   task automatic test_mid_reset();
      logic [16:0] e [4];
      logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      Instr = 32'h0050A023;
      e[0] = pack(1,0,2,2,0,0,1,1,0,0,0);
      e[1] = pack(1,1,1,0,0,0,0,0,0,0,0);
      e[2] = pack(1,2,1,0,0,0,0,0,0,0,0);
      e[3] = pack(1,0,0,0,1,0,0,0,0,1,0);
      for (int i = 0; i < 4; i++) begin
         MemReady = mr[i];
         #4;
         checks++;
         if (obs() !== e[i]) begin
            errors++; $display("FAIL mid_reset_seq cyc%0d got=%h exp=%h", i, obs(), e[i]);
         end
         if (i < 3) tick();
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || obs() !== 17'h0) begin
         errors++; $display("FAIL mid_reset_abort got=%h exp=%h", obs(), 17'h0);
      end
      tick();
      reset = 1'b1;
      MemReady = 1'b0;
      #4;
      checks++;
      if (obs() !== pack(1,0,2,2,0,0,0,0,0,0,0)) begin
         errors++; $display("FAIL mid_reset_fetch got=%h exp=%h", obs(), pack(1,0,2,2,0,0,0,0,0,0,0));
      end
      tick();
   endtask

   task automatic test_halt();
      logic [31:0] ins  [3] = '{32'h00000000, 32'h002091B3, 32'h0020A463};
      logic [16:0] hsig [3];
      hsig[0] = pack(0,0,0,0,0,0,0,0,0,0,1);
      hsig[1] = pack(0,0,0,0,0,0,0,0,0,0,1);
      hsig[2] = pack(2,0,0,0,0,0,0,0,0,0,1);
      {N, Z, C, V} = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         Instr = ins[k];
         MemReady = 1'b1;
         tick();
         tick();
         if (k == 2) begin
            #4;
            checks++;
            if (obs() !== pack(2,2,0,0,0,1,0,0,0,0,0)) begin
               errors++;
               $display("FAIL halt_branch_f3 got=%h exp=%h", obs(), pack(2,2,0,0,0,1,0,0,0,0,0));
            end
            tick();
         end else if (k == 1) begin
            tick();
         end
         for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (obs() !== hsig[k]) begin
               errors++;
               $display("FAIL halt instr=%h cyc%0d got=%h exp=%h", ins[k], i, obs(), hsig[k]);
            end
            tick();
         end
         reset = 1'b0;
         #2;
         checks++;
         if (obs() !== 17'h0) begin
            errors++; $display("FAIL halt_reset got=%h exp=%h", obs(), 17'h0);
         end
         tick();
         reset = 1'b1;
         MemReady = 1'b0;
         Instr = 32'h0;
         #4;
         checks++;
         if (obs() !== pack(0,0,2,2,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL halt_exit_fetch got=%h exp=%h", obs(), pack(0,0,2,2,0,0,0,0,0,0,0));
         end
         tick();
      end
      {N, Z, C, V} = 4'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_decode();
      test_lw_stall();
      test_sw();
      test_branch();
      test_jal();
`ifdef MULTICYCLE_CONTROLLER_INSTRET_EN
      test_instret();
`endif
      test_mid_reset();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Decodes the latched instruction and condition flags. Each cycle it drives every datapath select and enable: ImmSrc, ALUSrcA/B, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, plus the external MemWrite.
- Sits beside the datapath inside the CPU top.
- Adds a memory-ready handshake and illegal-opcode halt.

Parameters:
- RESET_STATE_FETCH, 1, state entered on reset (1 = FETCH; 0 = HALT, for bring-up benches).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  latched instruction (op = [6:0], funct3 = [14:12], funct7b5 = [30]).
- N, Z, C, V  in  1 each  ALU flags. C = carry-out of a+~b+1, so C=1 means a>=b unsigned.
- MemReady  in  1  memory completes the current access this cycle.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A.
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc  out  1  0 PC, 1 Result.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath and memory write enables.
- Halted  out  1  FSM parked in HALT.

Behaviour:
- Reset:
  - While reset=0, state = FETCH (or HALT per parameter).
  - All write enables are forced 0; all selects are 0.
- Output style:
  - Moore outputs come from state.
  - ImmSrc is combinational from op in every state: lw/I-ALU → I, sw → S, branch → B, jal → J, others → I.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE. PC and IR are never written on a non-ready cycle.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - otherwise → HALT
- MEMADR:
  - Drives ALUSrcA=10, ALUSrcB=01, add.
  - lw → MEMREAD; sw → MEMWRITE.
- MEMREAD:
  - Drives ResultSrc=00, AdrSrc=1.
  - Waits for MemReady, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE:
  - Drives ResultSrc=00, AdrSrc=1, MemWrite=1, held while MemReady=0.
  - → FETCH on MemReady.
- EXECUTER / EXECUTEI:
  - EXECUTER drives ALUSrcA=10, ALUSrcB=00; EXECUTEI drives ALUSrcA=10, ALUSrcB=01.
  - ALUControl is decoded; both go → ALUWB.
  - ALU decode by funct3:
    - 000: add, except sub when R-type and funct7b5=1.
    - 010: slt; 110: or; 111: and.
    - Any other funct3 → HALT instead of ALUWB.
  - I-type ignores funct7b5.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH:
  - Drives ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken, evaluated the same cycle from the live flags:
    - beq Z; bne !Z
    - blt N^V; bge !(N^V)
    - bltu !C; bgeu C
  - funct3 010/011 → HALT with PCWrite=0. Otherwise → FETCH.
- JAL:
  - Drives ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB.
  - ALUWB then writes OldPC+4 to rd.
- HALT:
  - All enables 0; Halted=1.
  - Exits only via reset.
- Simultaneous events and mid-op reset:
  - Reset asserted mid-instruction aborts immediately; no partial writes follow.
  - MemReady is ignored in states without a memory access.
- Latency (MemReady tied 1):
  - lw 5 cycles; sw 4; R/I 4; branch 3; jal 4.

Optional Feature:
- Macro: MULTICYCLE_CONTROLLER_INSTRET_EN.
- When defined:
  - Adds output InstrRet (1, pulses when an instruction completes) and Instret (32, retired-instruction counter).
  - Completion points are MEMWB, MEMWRITE with MemReady, ALUWB, and BRANCH.
  - The counter resets to 0 and wraps modulo 2^32.
  - HALT does not count.
- When undefined: ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUControl encodings;
  - ImmSrc, ALUSrcA/B, ResultSrc encodings.
- Sub-module alu_decoder: combinational, inputs (ALUOp class, funct3, funct7b5, op[5]), outputs ALUControl plus an illegal flag.

Test Plan:
- add x3,x1,x2 with MemReady=1 → FETCH, DECODE, EXECUTER, ALUWB, FETCH in 4 cycles. ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB.
- lw with MemReady held 0 for 3 cycles in MEMREAD → FSM stays in MEMREAD; RegWrite=0 until MEMWB; total 8 cycles.
- beq with Z=1 then Z=0 → PCWrite=1 in BRANCH, then PCWrite=0; both return to FETCH after 3 cycles.
- bltu with C=0 → taken; bgeu with C=0 → not taken.
- Opcode 0000000 → HALT after DECODE with Halted=1 and all enables 0. Reset pulse low → FETCH.
- Reset asserted mid-MEMWRITE → MemWrite drops to 0 asynchronously. With INSTRET_EN, Instret counts 3 after add, sw, jal.
